// File: rtl/fp_normalizer_pkg.sv
// Shared floating-point definitions for the post-add normalizer:
// field widths, the saturating exponent value and the FSM state type.
package fp_normalizer_pkg;

  localparam int EXP_W = 8;
  localparam int MANT_W = 24;
  localparam int RES_W = 1 + EXP_W + (MANT_W - 1);
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic {
    IDLE = 1'b0,
    NORM = 1'b1
  } state_t;

endpackage

// File: rtl/fp_normalizer_if.sv
// Operand/result bundle between the mantissa adder stage and the normalizer.
// The master drives operands and the enable; the slave (normalizer) returns
// the packed IEEE-754 single result and its status flags.
interface fp_normalizer_if;
  import fp_normalizer_pkg::*;

  logic              en;
  logic              start;
  logic [MANT_W-1:0] sum;
  logic              c_out;
  logic              sign;
  logic [EXP_W-1:0]  exp_in;
  logic [RES_W-1:0]  result;
  logic              ready;
  logic              busy;
  logic              overflow;

  modport master (
    output en, start, sum, c_out, sign, exp_in,
    input  result, ready, busy, overflow
  );

  modport slave (
    input  en, start, sum, c_out, sign, exp_in,
    output result, ready, busy, overflow
  );

endinterface

// File: rtl/fp_normalizer.sv
// Post-addition normalizer. Takes the raw adder magnitude, carry, sign and
// aligned exponent, then normalizes one bit per cycle (right shift on carry,
// left shifts until the hidden bit is set or the exponent bottoms out into a
// denormal) and emits a packed single-precision result. Rounding is plain
// truncation.
module fp_normalizer
  import fp_normalizer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  fp_normalizer_if.slave  bus
);

  state_t            state_reg, state_next;
  logic [MANT_W-1:0] mant_reg, mant_next;
  logic [EXP_W-1:0]  exp_reg, exp_next;
  logic              carry_reg, carry_next;
  logic              sign_reg, sign_next;
  logic [RES_W-1:0]  result_reg, result_next;
  logic              ready_reg, ready_next;
  logic              overflow_reg, overflow_next;

  logic [EXP_W-1:0]  exp_inc;
  logic [RES_W-1:0]  infinity_word;

  assign exp_inc       = exp_reg + 8'd1;
  assign infinity_word = {sign_reg, EXP_MAX, {(MANT_W-1){1'b0}}};

  // FSM state register; reset may strike mid-normalization
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath and output registers, all frozen when en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant_reg     <= '0;
      exp_reg      <= '0;
      carry_reg    <= 1'b0;
      sign_reg     <= 1'b0;
      result_reg   <= '0;
      ready_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      mant_reg     <= mant_next;
      exp_reg      <= exp_next;
      carry_reg    <= carry_next;
      sign_reg     <= sign_next;
      result_reg   <= result_next;
      ready_reg    <= ready_next;
      overflow_reg <= overflow_next;
    end
  end

  // Next-state and one-step normalization; the checks are ordered by priority
  always_comb begin
    state_next    = state_reg;
    mant_next     = mant_reg;
    exp_next      = exp_reg;
    carry_next    = carry_reg;
    sign_next     = sign_reg;
    result_next   = result_reg;
    ready_next    = ready_reg;
    overflow_next = overflow_reg;

    if (bus.en) begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            mant_next     = bus.sum;
            carry_next    = bus.c_out;
            sign_next     = bus.sign;
            exp_next      = bus.exp_in;
            ready_next    = 1'b0;
            overflow_next = 1'b0;
            state_next    = NORM;
          end
        end

        NORM: begin
          if (exp_reg == EXP_MAX) begin
            // Operand already at the infinity/NaN exponent: saturate
            result_next   = infinity_word;
            overflow_next = 1'b1;
            ready_next    = 1'b1;
            state_next    = IDLE;
          end else if (carry_reg) begin
            carry_next = 1'b0;
            if (exp_inc == EXP_MAX) begin
              // Bumping the exponent would land on all-ones: saturate
              result_next   = infinity_word;
              overflow_next = 1'b1;
              ready_next    = 1'b1;
              state_next    = IDLE;
            end else begin
              // Carry becomes the new hidden bit; LSB is truncated away
              mant_next = {1'b1, mant_reg[MANT_W-1:1]};
              exp_next  = exp_inc;
            end
          end else if (mant_reg == '0) begin
            // Exact cancellation always yields +0
            result_next = '0;
            ready_next  = 1'b1;
            state_next  = IDLE;
          end else if (mant_reg[MANT_W-1]) begin
            result_next = {sign_reg, exp_reg, mant_reg[MANT_W-2:0]};
            ready_next  = 1'b1;
            state_next  = IDLE;
          end else if (exp_reg <= 8'd1) begin
            // Cannot shift further without underflowing: emit denormal as is
            result_next = {sign_reg, {EXP_W{1'b0}}, mant_reg[MANT_W-2:0]};
            ready_next  = 1'b1;
            state_next  = IDLE;
          end else begin
            mant_next = {mant_reg[MANT_W-2:0], 1'b0};
            exp_next  = exp_reg - 8'd1;
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.result   = result_reg;
  assign bus.ready    = ready_reg;
  assign bus.overflow = overflow_reg;
  assign bus.busy     = (state_reg == NORM);

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed and randomized bench for fp_normalizer. Expected results and
// latencies come from an arithmetic reference model (leading-zero count,
// exponent clamping) rather than a cycle-by-cycle copy of the FSM.
module tb_fp_normalizer;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  fp_normalizer_if bus ();

  fp_normalizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: result, overflow flag and edges from start to ready
  task automatic model(input logic [23:0] s_sum, input logic s_c, input logic s_sign,
                       input logic [7:0] s_exp, output logic [31:0] res,
                       output logic ov, output int lat);
    int lz;
    int allowed;
    logic [23:0] m;
    ov = 1'b0;
    if (s_exp == 8'hFF) begin
      res = {s_sign, 8'hFF, 23'd0};
      ov  = 1'b1;
      lat = 2;
    end else if (s_c) begin
      if (s_exp == 8'hFE) begin
        res = {s_sign, 8'hFF, 23'd0};
        ov  = 1'b1;
        lat = 2;
      end else begin
        res = {s_sign, 8'(s_exp + 1), s_sum[23:1]};
        lat = 3;
      end
    end else if (s_sum == 24'd0) begin
      res = 32'd0;
      lat = 2;
    end else begin
      lz = 0;
      while (lz < 24 && !s_sum[23-lz]) lz++;
      allowed = (s_exp >= 1) ? int'(s_exp) - 1 : 0;
      if (lz <= allowed) begin
        m   = s_sum << lz;
        res = {s_sign, 8'(int'(s_exp) - lz), m[22:0]};
        lat = lz + 2;
      end else begin
        m   = s_sum << allowed;
        res = {s_sign, 8'd0, m[22:0]};
        lat = allowed + 2;
      end
    end
  endtask

  // One operand: drive, wait for ready (bounded), compare against the model.
  // pause_at > 0 drops en for 5 edges; inject fires a second start mid-NORM.
  task automatic run_op(input logic [23:0] s_sum, input logic s_c, input logic s_sign,
                        input logic [7:0] s_exp, input int pause_at, input bit inject,
                        input string tag);
    logic [31:0] exp_res;
    logic        exp_ov;
    int          exp_lat;
    int          edges;
    logic        busy_ok;
    model(s_sum, s_c, s_sign, s_exp, exp_res, exp_ov, exp_lat);
    if (pause_at > 0) exp_lat += 5;
    @(negedge clk);
    bus.sum    = s_sum;
    bus.c_out  = s_c;
    bus.sign   = s_sign;
    bus.exp_in = s_exp;
    bus.en     = 1'b1;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    edges     = 1;
    busy_ok   = 1'b1;
    while (!bus.ready && edges < 300) begin
      if (!bus.busy) busy_ok = 1'b0;
      bus.en = !(pause_at > 0 && edges >= pause_at && edges < pause_at + 5);
      if (inject && edges == 2) begin
        bus.start  = 1'b1;
        bus.sum    = 24'h123456;
        bus.exp_in = 8'h10;
        bus.c_out  = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    bus.en    = 1'b1;
    bus.start = 1'b0;
    $display("op %s sum=%h c=%b s=%b e=%h -> result=%h ov=%b latency=%0d", tag,
             s_sum, s_c, s_sign, s_exp, bus.result, bus.overflow, edges);
    check({tag, ".result"}, bus.result, exp_res);
    check({tag, ".overflow"}, 32'(bus.overflow), 32'(exp_ov));
    check({tag, ".latency"}, 32'(edges), 32'(exp_lat));
    check({tag, ".busy_during"}, 32'(busy_ok), 32'd1);
    check({tag, ".busy_after"}, 32'(bus.busy), 32'd0);
    // Result and ready must hold while idle
    @(negedge clk);
    @(negedge clk);
    check({tag, ".hold_result"}, bus.result, exp_res);
    check({tag, ".hold_ready"}, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    logic [23:0] r_sum;
    logic        r_c;
    logic        r_sign;
    logic [7:0]  r_exp;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.start   = 1'b0;
    bus.sum     = '0;
    bus.c_out   = 1'b0;
    bus.sign    = 1'b0;
    bus.exp_in  = '0;

    #2;
    check("reset.result", bus.result, 32'd0);
    check("reset.ready", 32'(bus.ready), 32'd0);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(24'hC00000, 1'b0, 1'b0, 8'h7F, 0, 1'b0, "normal");
    check("normal.value", bus.result, 32'h3FC00000);
    run_op(24'h000000, 1'b1, 1'b0, 8'h7F, 0, 1'b0, "carry");
    check("carry.value", bus.result, 32'h40000000);
    run_op(24'h000001, 1'b0, 1'b1, 8'h7F, 0, 1'b0, "full_shift");
    check("full_shift.value", bus.result, 32'hB4000000);
    run_op(24'h000000, 1'b0, 1'b1, 8'h40, 0, 1'b0, "neg_zero");
    check("neg_zero.value", bus.result, 32'h00000000);
    run_op(24'h800000, 1'b1, 1'b0, 8'hFE, 0, 1'b0, "carry_ovf");
    check("carry_ovf.value", bus.result, 32'h7F800000);
    run_op(24'h000001, 1'b0, 1'b0, 8'h03, 0, 1'b0, "denormal");
    check("denormal.value", bus.result, 32'h00000004);
    run_op(24'h400000, 1'b0, 1'b1, 8'hFF, 0, 1'b0, "exp_max");
    run_op(24'h000001, 1'b0, 1'b0, 8'h7F, 0, 1'b1, "start_in_norm");
    run_op(24'h000001, 1'b0, 1'b1, 8'h7F, 3, 1'b0, "en_pause");

    // en low in IDLE must not accept a start
    @(negedge clk);
    bus.en    = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    check("en_idle.busy", 32'(bus.busy), 32'd0);
    check("en_idle.ready", 32'(bus.ready), 32'd1);
    bus.start = 1'b0;
    bus.en    = 1'b1;

    // Asynchronous reset in the middle of a long normalization
    @(negedge clk);
    bus.sum    = 24'h000001;
    bus.c_out  = 1'b0;
    bus.sign   = 1'b1;
    bus.exp_in = 8'h7F;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("midreset.busy_before", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset.result", bus.result, 32'd0);
    check("midreset.ready", 32'(bus.ready), 32'd0);
    check("midreset.busy", 32'(bus.busy), 32'd0);
    check("midreset.overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(24'h600000, 1'b0, 1'b0, 8'h80, 0, 1'b0, "after_reset");

    // Randomized operands biased toward the interesting corners
    for (int n = 0; n < 40; n++) begin
      r_sum  = 24'($urandom) >> $urandom_range(0, 24);
      if ($urandom_range(0, 15) == 0) r_sum = 24'd0;
      r_c    = ($urandom_range(0, 7) == 0);
      r_sign = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       r_exp = 8'($urandom_range(0, 3));
        1:       r_exp = 8'($urandom_range(252, 255));
        default: r_exp = 8'($urandom_range(0, 255));
      endcase
      run_op(r_sum, r_c, r_sign, r_exp, 0, 1'b0, $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_normalizer.md
FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  async active-low reset.
REQ-004 SHALL have port: en  input  1  clock enable; 0 freezes all state.
REQ-005 SHALL have port: start  input  1  request to load a new operand.
REQ-006 SHALL have port: sum  input  24  raw mantissa magnitude from the mantissa adder.
REQ-007 SHALL have port: c_out  input  1  adder carry-out.
REQ-008 SHALL have port: sign  input  1  result sign from the adder.
REQ-009 SHALL have port: exp_in  input  8  biased exponent of the aligned (larger) operand.
REQ-010 SHALL have port: result  output  32  IEEE-754 single {sign, exp[7:0], mant[22:0]}.
REQ-011 SHALL have port: ready  output  1  level; result valid.
REQ-012 SHALL have port: busy  output  1  high while NORM.
REQ-013 SHALL have port: overflow  output  1  result saturated to infinity.

Function
REQ-014 SHALL implement FSM states IDLE and NORM.
REQ-015 In IDLE with en=1 and start=1, SHALL latch sum, c_out, sign and exp_in, clear ready and overflow, and go to NORM.
REQ-016 SHALL ignore start while in NORM.
REQ-017 NORM priority 1: if exp_in latched = 8'hFF, SHALL write {sign, 8'hFF, 23'b0}, set overflow, and terminate.
REQ-018 NORM priority 2: if carry flag=1, SHALL set mant={1, mant[23:1]} and exp=exp+1, clear carry, and stay in NORM; if exp+1=8'hFF, SHALL write infinity, set overflow, and terminate.
REQ-019 NORM priority 3: if mant=0, SHALL write 32'h00000000 (positive zero regardless of sign) and terminate.
REQ-020 NORM priority 4: if mant[23]=1, SHALL write {sign, exp, mant[22:0]} and terminate.
REQ-021 NORM priority 5: if exp<=1, SHALL write the denormal {sign, 8'h00, mant[22:0]} unshifted and terminate.
REQ-022 NORM otherwise: SHALL shift mant left by 1, set exp=exp-1, and stay in NORM.
REQ-023 Termination SHALL register result, set ready=1 and return to IDLE on the same edge.
REQ-024 ready SHALL then hold 1 and result SHALL hold until the next accepted start.
REQ-025 Latency SHALL be 1 + (number of shift cycles) NORM evaluations after the start edge; an already-normal input gives ready two edges after start.
REQ-026 Rounding SHALL be truncation; the bit shifted out on a right shift is discarded.
REQ-027 With en=0, SHALL hold FSM, mantissa, exponent and outputs unchanged, including mid-NORM.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, result=0, ready=0, busy=0, overflow=0, and clear internal mantissa, exponent and carry, including mid-NORM.
REQ-029 The first start after reset release SHALL be accepted normally.

Structure
REQ-030 A shared fp package SHALL hold EXP_W=8, MANT_W=24, EXP_MAX=8'hFF, and the FSM state enum.
REQ-031 SHALL be a single module with no sub-module; the one-bit shifter and exponent update are inline.

Verification
REQ-032 Normal case: sum=24'hC00000, c_out=0, sign=0, exp_in=8'h7F -> result=32'h3FC00000, ready two edges after start.
REQ-033 Carry case: c_out=1, sum=24'h000000, exp_in=8'h7F -> result=32'h40000000 after three edges.
REQ-034 Full left shift: sum=24'h000001, sign=1, exp_in=8'h7F -> 23 shifts -> result=32'hB4000000 after 25 edges, busy high throughout.
REQ-035 Boundaries:
- sum=0, c_out=0, sign=1 -> 32'h00000000.
- c_out=1, exp_in=8'hFE -> 32'h7F800000 with overflow=1.
- sum=24'h000001, exp_in=8'h03 -> 32'h00000004.
REQ-036 Control:
- start during NORM is ignored (result from the first operand).
- en=0 for 5 cycles mid-NORM stretches latency by exactly 5.
- rst_n low mid-NORM clears all outputs asynchronously.
